// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, fetch-buffer entry type and PC helpers
// Provides XLEN/INST_W, the sequential PC step, the default reset PC,
// the {pc, data, filled} buffer entry and a word-alignment helper.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int INST_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] data;
        logic              filled;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~32'd3;
    endfunction
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry in-order allocate/fill/pop instruction buffer with flush
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   i_flush          drop every entry (takes priority over alloc/fill/pop)
//   i_alloc/_pc      reserve the tail entry for a request at i_alloc_pc
//   i_fill/_data     write the oldest unfilled entry and mark it filled
//   i_pop            free the head entry
//   o_cnt            allocated entries
//   o_unfilled       allocated entries still waiting for their response
//   o_head_*         head entry is filled, plus its pc and instruction
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_alloc,
    input  logic [XLEN-1:0]   i_alloc_pc,
    input  logic              i_fill,
    input  logic [INST_W-1:0] i_fill_data,
    input  logic              i_pop,
    output logic [AW:0]       o_cnt,
    output logic [AW:0]       o_unfilled,
    output logic              o_head_valid,
    output logic [XLEN-1:0]   o_head_pc,
    output logic [INST_W-1:0] o_head_data
);
    // Pointers carry one extra wrap bit so a full buffer differs from an empty one.
    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_head, r_tail, r_fill;
    logic [AW-1:0] w_head_idx, w_tail_idx, w_fill_idx;

    assign w_head_idx   = r_head[AW-1:0];
    assign w_tail_idx   = r_tail[AW-1:0];
    assign w_fill_idx   = r_fill[AW-1:0];
    assign o_cnt        = r_tail - r_head;
    assign o_unfilled   = r_tail - r_fill;
    // A freed slot keeps its stale filled bit, so emptiness must gate the head.
    assign o_head_valid = (r_tail != r_head) && r_mem[w_head_idx].filled;
    assign o_head_pc    = r_mem[w_head_idx].pc;
    assign o_head_data  = r_mem[w_head_idx].data;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
        end else begin
            if (i_alloc) r_tail <= r_tail + 1'b1;
            if (i_fill)  r_fill <= r_fill + 1'b1;
            if (i_pop)   r_head <= r_head + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k].filled <= 1'b0;
        end else begin
            if (i_alloc) begin
                r_mem[w_tail_idx].pc     <= i_alloc_pc;
                r_mem[w_tail_idx].filled <= 1'b0;
            end
            if (i_fill) begin
                r_mem[w_fill_idx].data   <= i_fill_data;
                r_mem[w_fill_idx].filled <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC, issuing requests and buffering responses
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect reporting).
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   imem_req_valid/ready/addr      word-aligned fetch request to instruction memory
//   imem_rsp_valid/data            in-order responses, one per accepted request
//   inst_valid/ready/data/pc       {pc, instruction} handshake to decode
//   redirect_valid/pc              control-flow change from execute (highest priority)
//   misalign_err                   one-cycle pulse after a misaligned redirect (0 if compiled out)
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              misalign_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(2 * DEPTH + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [DW-1:0]   r_discard;
    logic [DW-1:0]   w_discard_nxt;
    logic [AW:0]     w_cnt, w_unfilled;
    logic            w_req_hs, w_fill, w_pop;

    assign imem_req_valid = !rst && (w_cnt < FULL);
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;
    assign w_fill         = imem_rsp_valid && (r_discard == '0);
    assign w_pop          = inst_valid && inst_ready;

    // On redirect every fetch not yet answered becomes stale: unfilled entries,
    // plus a request accepted this cycle, less the response consumed this cycle
    // (which either fills an unfilled entry or retires one pending discard).
    assign w_discard_nxt = redirect_valid
        ? r_discard + DW'(w_unfilled) + DW'(w_req_hs) - DW'(imem_rsp_valid)
        : r_discard - DW'(imem_rsp_valid && (r_discard != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else begin
            r_discard <= w_discard_nxt;
            r_pc      <= redirect_valid ? align_pc(redirect_pc) : w_req_hs ? r_pc + PC_STEP : r_pc;
        end
    end

    fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect_valid),
        .i_alloc      (w_req_hs),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_fill),
        .i_fill_data  (imem_rsp_data),
        .i_pop        (w_pop),
        .o_cnt        (w_cnt),
        .o_unfilled   (w_unfilled),
        .o_head_valid (inst_valid),
        .o_head_pc    (inst_pc),
        .o_head_data  (inst_data)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;
    always_ff @(posedge clk) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
    assign misalign_err = r_misalign;
`else
    assign misalign_err = 1'b0;
`endif
endmodule
